xnor_seq_cmp: RTL and testbench

- Parametrised, sequential successor to the single-bit XNOR gate block.
- Latches two WIDTH-bit operands on a start request and processes them CHUNK bits per clock, LSB chunk first.
- Produces three results: the bitwise XNOR (or XOR) result word, a popcount of the result bits, and an equality flag.
- Serves as the multi-bit compare/match unit in the team's datapath exercises; start/busy/done handshake.

---
 rtl/xnor_seq_cmp_pkg.sv | 14 +
 rtl/xnor_seq_cmp_chunk.sv | 29 ++
 rtl/xnor_seq_cmp.sv | 166 ++++++++++++++++
 tb/tb_xnor_seq_cmp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xnor_seq_cmp_pkg.sv
// Shared definitions for the sequential XNOR/XOR compare unit:
// FSM state encoding and operation mode constants.
package xnor_seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_XNOR = 1'b0;
  localparam logic MODE_XOR  = 1'b1;

endpackage : xnor_seq_cmp_pkg

// File: rtl/xnor_seq_cmp_chunk.sv
// Combinational per-chunk compare slice.
// Ports:
//   a, b  : CHUNK-bit operand slices
//   mode  : 0 = XNOR (match), 1 = XOR (difference)
//   r_c   : CHUNK-bit result slice
//   pc_c  : number of 1 bits in r_c
module xnor_chunk
  import xnor_seq_cmp_pkg::*;
#(
  parameter  int unsigned CHUNK = 2,
  localparam int unsigned PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  output logic [CHUNK-1:0] r_c,
  output logic [PW-1:0]    pc_c
);

  // Result slice and its popcount
  always_comb begin
    r_c  = (mode == MODE_XOR) ? (a ^ b) : ~(a ^ b);
    pc_c = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      pc_c = pc_c + PW'(r_c[i]);
    end
  end

endmodule : xnor_chunk

// File: rtl/xnor_seq_cmp.sv
// Sequential WIDTH-bit XNOR/XOR compare unit. Latches operands on start,
// processes CHUNK bits per clock (LSB chunk first), then reports the
// result word, its popcount and an equality flag with a one-cycle done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   mode       : 0 = XNOR, 1 = XOR; latched with operands
//   a, b       : WIDTH-bit operands, latched on accepted start
//   busy       : high while processing chunks
//   done       : one-cycle pulse when s/count/eq update
//   s          : result word
//   count      : number of 1 bits in s
//   eq         : latched a == b
module xnor_seq_cmp
  import xnor_seq_cmp_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CHUNK = 2,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [CW-1:0]    count,
  output logic             eq
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = $clog2(CHUNK + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   acc_s_q, acc_s_d;
  logic [CW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               busy_d, done_d, eq_d;
  logic [WIDTH-1:0]   s_d;
  logic [CW-1:0]      count_d;

  logic [CHUNK-1:0]   a_chunk_c, b_chunk_c, r_c;
  logic [PW-1:0]      pc_c;
  logic [CW-1:0]      cnt_sum_c;
  logic               last_c;

  // Select the current chunk of the latched operands
  always_comb begin
    a_chunk_c = '0;
    b_chunk_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx_q == IW'(k)) begin
        a_chunk_c = a_q[k*CHUNK +: CHUNK];
        b_chunk_c = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  xnor_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_chunk_c),
    .b    (b_chunk_c),
    .mode (mode_q),
    .r_c  (r_c),
    .pc_c (pc_c)
  );

  assign cnt_sum_c = acc_cnt_q + CW'(pc_c);
  assign last_c    = (idx_q == IW'(N - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    acc_s_d   = acc_s_q;
    acc_cnt_d = acc_cnt_q;
    idx_d     = idx_q;
    busy_d    = busy;
    done_d    = 1'b0;
    s_d       = s;
    count_d   = count;
    eq_d      = eq;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          mode_d    = mode;
          acc_s_d   = '0;
          acc_cnt_d = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < int'(N); k++) begin
          if (idx_q == IW'(k)) acc_s_d[k*CHUNK +: CHUNK] = r_c;
        end
        acc_cnt_d = cnt_sum_c;
        idx_d     = idx_q + IW'(1);
        if (last_c) begin
          // Publish including the chunk processed on this edge
          s_d     = acc_s_d;
          count_d = cnt_sum_c;
          eq_d    = (mode_q == MODE_XNOR) ? (cnt_sum_c == CW'(WIDTH))
                                          : (cnt_sum_c == '0);
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      acc_s_q   <= '0;
      acc_cnt_q <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s         <= '0;
      count     <= '0;
      eq        <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      acc_s_q   <= acc_s_d;
      acc_cnt_q <= acc_cnt_d;
      idx_q     <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
      s         <= s_d;
      count     <= count_d;
      eq        <= eq_d;
    end
  end

endmodule : xnor_seq_cmp

// File: tb/tb_xnor_seq_cmp.sv
// Self-checking bench for xnor_seq_cmp: a CHUNK=2 instance and a
// CHUNK=8 instance, both WIDTH=8, checked against a word-level model.
module tb_xnor_seq_cmp;

  localparam int W  = 8;
  localparam int N2 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode;
  logic [7:0] a, b;
  logic       busy, done, eq;
  logic [7:0] s;
  logic [3:0] count;

  logic       start8, mode8;
  logic [7:0] a8, b8;
  logic       busy8, done8, eq8;
  logic [7:0] s8;
  logic [3:0] count8;

  int n_vec = 0;
  int n_err = 0;

  // Last published results of the CHUNK=2 instance (for hold checks)
  logic [7:0] p_s;
  logic [3:0] p_c;
  logic       p_e;

  always #5 clk = ~clk;

  xnor_seq_cmp #(.WIDTH(W), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .count(count), .eq(eq)
  );

  xnor_seq_cmp #(.WIDTH(W), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .count(count8), .eq(eq8)
  );

  // Word-level reference model
  function automatic logic [7:0] ref_s(input logic [7:0] x, input logic [7:0] y,
                                       input logic m);
    return m ? (x ^ y) : ~(x ^ y);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; mode = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0;
    tick; tick;
    n_vec++;
    if ({busy, done, s, count, eq} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_c2: busy=%b done=%b s=%h count=%0d eq=%b, want all 0",
               busy, done, s, count, eq);
    end
    n_vec++;
    if ({busy8, done8, s8, count8, eq8} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_c8: busy=%b done=%b s=%h count=%0d eq=%b, want all 0",
               busy8, done8, s8, count8, eq8);
    end
    rst_n = 1'b1;
    p_s = '0; p_c = '0; p_e = 1'b0;
    tick;
  endtask

  // One operation on the CHUNK=2 instance; inputs are scrambled during RUN
  // and, with glitch set, start is re-pulsed in the second RUN cycle.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input logic m, input bit glitch);
    logic [7:0] es;
    logic [3:0] ec;
    logic       ee;
    es = ref_s(x, y, m);
    ec = 4'($countones(es));
    ee = (x == y);
    a = x; b = y; mode = m; start = 1'b1;
    tick;
    for (int i = 0; i < N2; i++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL run_busy cyc%0d: busy=%b done=%b, want busy=1 done=0",
                 i, busy, done);
      end
      n_vec++;
      if (s !== p_s || count !== p_c || eq !== p_e) begin
        n_err++;
        $display("FAIL run_hold cyc%0d: s=%h count=%0d eq=%b, want s=%h count=%0d eq=%b",
                 i, s, count, eq, p_s, p_c, p_e);
      end
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
      start = (glitch && i == 1) ? 1'b1 : 1'b0;
      tick;
    end
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b busy=%b, want done=1 busy=0", done, busy);
    end
    n_vec++;
    if (s !== es || count !== ec || eq !== ee) begin
      n_err++;
      $display("FAIL result a=%h b=%h m=%b: s=%h count=%0d eq=%b, want s=%h count=%0d eq=%b",
               x, y, m, s, count, eq, es, ec, ee);
    end
    p_s = es; p_c = ec; p_e = ee;
    tick;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL after_done: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_directed;
    run_op(8'hA5, 8'hA5, 1'b0, 1'b0);
    run_op(8'h0F, 8'h00, 1'b1, 1'b0);
    run_op(8'h3C, 8'h3C, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start;
    run_op(8'h00, 8'hFF, 1'b0, 1'b1);
    // The re-pulsed start must not have queued a second operation
    for (int i = 0; i < N2 + 2; i++) begin
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL ignore_start cyc%0d: done=%b busy=%b, want 0 0", i, done, busy);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    a = 8'hF0; b = 8'hF0; mode = 1'b0; start = 1'b1;
    tick;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < N2; i++) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || s !== p_s || count !== p_c || eq !== p_e) begin
          n_err++;
          $display("FAIL b2b_run rep%0d cyc%0d: busy=%b done=%b s=%h count=%0d eq=%b, want 1 0 %h %0d %b",
                   rep, i, busy, done, s, count, eq, p_s, p_c, p_e);
        end
        tick;
      end
      n_vec++;
      if (done !== 1'b1 || s !== 8'hFF || count !== 4'd8 || eq !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_done rep%0d: done=%b s=%h count=%0d eq=%b, want 1 ff 8 1",
                 rep, done, s, count, eq);
      end
      p_s = 8'hFF; p_c = 4'd8; p_e = 1'b1;
      start = (rep < 2);
      tick;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle rep%0d: busy=%b done=%b, want 0 0", rep, busy, done);
      end
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    a = 8'h12; b = 8'h34; mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, s, count, eq} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b s=%h count=%0d eq=%b, want all 0",
               busy, done, s, count, eq);
    end
    p_s = '0; p_c = '0; p_e = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < N2 + 2; i++) begin
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_abort cyc%0d: done=%b busy=%b, want 0 0", i, done, busy);
      end
      tick;
    end
    run_op(8'h5A, 8'h5B, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] x, y;
    for (int k = 0; k < 16; k++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
      run_op(x, y, 1'($urandom), bit'($urandom_range(0, 1)));
    end
  endtask

  // One operation on the CHUNK=8 instance
  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic [7:0] es;
    es = ref_s(x, y, m);
    a8 = x; b8 = y; mode8 = m; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    n_vec++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_err++;
      $display("FAIL c8_busy: busy=%b done=%b, want 1 0", busy8, done8);
    end
    tick;
    n_vec++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || s8 !== es ||
        count8 !== 4'($countones(es)) || eq8 !== (x == y)) begin
      n_err++;
      $display("FAIL c8_result a=%h b=%h m=%b: done=%b busy=%b s=%h count=%0d eq=%b, want 1 0 %h %0d %b",
               x, y, m, done8, busy8, s8, count8, eq8, es, $countones(es), (x == y));
    end
    tick;
    n_vec++;
    if (done8 !== 1'b0) begin
      n_err++;
      $display("FAIL c8_after: done=%b, want 0", done8);
    end
  endtask

  task automatic test_chunk_full;
    run_op8(8'h81, 8'h01, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom));
    end
    run_op8(8'hC3, 8'hC3, 1'b1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    test_chunk_full;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_xnor_seq_cmp
